// File: rtl/bcode_uart_tx_pkg.sv
// Shared types and defaults for the IRIG-B byte-stream UART transmitter.
package bcode_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per UART bit; the fractional part is truncated.
  function automatic int calc_bit_cyc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  localparam int DEF_CLK_FREQ   = 125_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_BIT_CYC    = calc_bit_cyc(DEF_CLK_FREQ, DEF_BAUD);
  localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/bcode_uart_tx_if.sv
// Byte-stream input from the IRIG-B parser plus the serial-side status outputs.
interface bcode_uart_tx_if;
  logic [7:0] ip_data;
  logic       ip_flag;
  logic       uart_tx;
  logic       tx_busy;
  logic       fifo_ovf;

  modport master (output ip_data, ip_flag, input uart_tx, tx_busy, fifo_ovf);
  modport slave  (input ip_data, ip_flag, output uart_tx, tx_busy, fifo_ovf);
endinterface

// File: rtl/bcode_uart_tx_byte_fifo.sv
// First-word-fall-through byte FIFO. The caller gates wr_en/rd_en against
// full/empty; a write while full is only issued together with a read.
module byte_fifo
  import bcode_uart_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Head byte is presented combinationally so a pop can latch it directly.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
endmodule

// File: rtl/bcode_uart_tx.sv
// Buffers parsed IRIG-B time bytes and sends them as 8N1 LSB-first UART frames.
module bcode_uart_tx
  import bcode_uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic             clk,
  input logic             rst_n,
  bcode_uart_tx_if.slave  bus
);
  localparam int BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD);
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYC - 1);

  tx_state_t     state_reg, state_next;
  logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          ovf_reg, ovf_next;

  logic       push, pop, baud_last;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty, fifo_full;

  // A push at full is still accepted when the same cycle pops a slot free.
  assign push      = bus.ip_flag && (!fifo_full || pop);
  assign baud_last = (baud_cnt_reg == BAUD_LAST);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (bus.ip_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Next-state, counters and the registered line level for the next cycle.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          shift_next    = fifo_rd_data;
          baud_cnt_next = '0;
          state_next    = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) state_next = STOP;
          else bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: no idle bit between stop and next start.
            pop        = 1'b1;
            shift_next = fifo_rd_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are computed from the next state so they are registered, not decoded.
    tx_next   = (state_next == START) ? 1'b0 :
                (state_next == DATA)  ? shift_next[0] : 1'b1;
    busy_next = (state_next != IDLE);
    ovf_next  = ovf_reg | (bus.ip_flag & fifo_full & ~pop);
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign bus.uart_tx  = tx_reg;
  assign bus.tx_busy  = busy_reg;
  assign bus.fifo_ovf = ovf_reg;
endmodule

// File: doc/bcode_uart_tx.md
Name: bcode_uart_tx

Overview:
- Downstream consumer of the IRIG-B parser's byte stream (ip_data / ip_flag).
- Buffers decoded time bytes in a small synchronous FIFO and serialises them on a UART TX line (8N1, LSB first) toward the host PC.
- Sits between the IRIG-B processing top and the board UART pin, in the same 125 MHz clock domain.

Parameters:
- CLK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate.
- FIFO_DEPTH, 16, byte FIFO depth; power of two, minimum 4.

Ports:
- clk  input  1  system clock, 125 MHz.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ip_data  input  8  parsed time byte from the IRIG-B parser.
- ip_flag  input  1  single-cycle strobe; ip_data is valid in the same cycle.
- uart_tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame (start, data or stop bit) is on the line.
- fifo_ovf  output  1  sticky flag: at least one byte was dropped because the FIFO was full.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - Reset values: uart_tx=1, tx_busy=0, fifo_ovf=0, FIFO empty, state IDLE, bit and baud counters 0.
  - Reset asserted mid-frame aborts the frame; the line returns high immediately and all buffered bytes are discarded.
- Baud timing:
  - BIT_CYC = CLK_FREQ/BAUD, integer-truncated; 1085 with the defaults.
  - The baud counter counts 0..BIT_CYC-1, so each bit lasts exactly BIT_CYC cycles and a frame lasts 10*BIT_CYC cycles (10850 with the defaults).
- FIFO write:
  - A byte is written when ip_flag=1 and the FIFO is not full.
  - If ip_flag=1 while the FIFO is full and no pop occurs in that cycle, the byte is dropped and fifo_ovf is set; fifo_ovf stays set until reset.
  - If ip_flag=1 while full and a pop occurs in the same cycle, the push is accepted and the count is unchanged.
  - A push and a pop in the same cycle when not full also leave the count unchanged.
- FSM (IDLE, START, DATA, STOP):
  - IDLE: uart_tx=1, tx_busy=0. If the FIFO is non-empty: pop, latch the head byte into the shift register, go to START.
  - START: uart_tx=0 for BIT_CYC cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for BIT_CYC cycles, then shift right. After bit index 7, go to STOP.
  - STOP: uart_tx=1 for BIT_CYC cycles. At the last stop cycle:
    - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
    - FIFO empty: go to IDLE.
  - tx_busy=1 in START, DATA and STOP.
  - uart_tx and tx_busy are registered outputs.
- Latency, empty FIFO and idle line:
  - ip_flag at cycle N → FIFO non-empty at N+1 → pop at N+1 → uart_tx falls and tx_busy rises at N+2.
  - ip_flag inputs arrive as single-cycle pulses; consecutive-cycle pulses are legal and each writes one byte.
- Throughput: one byte per 10*BIT_CYC cycles. Bursts longer than FIFO_DEPTH plus 1 (the byte in flight) overflow.

Decomposition:
- Package bcode_uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP);
  - the function calc_bit_cyc(clk_freq, baud);
  - localparam defaults for the 125 MHz / 115200 configuration.
- Sub-module byte_fifo (parameter DEPTH, inputs wr_en/wr_data/rd_en, outputs rd_data/empty/full):
  - first-word-fall-through;
  - pointer width = $clog2(DEPTH) + 1.
- The top module holds the FSM, the baud counter, the bit counter, the shift register and the overflow logic.

Test Plan:
- Idle after reset: release rst_n, no ip_flag for 20000 cycles → uart_tx=1, tx_busy=0, fifo_ovf=0 throughout.
- Single byte: ip_flag with ip_data=8'h35 at cycle N → uart_tx falls at N+2. Sampling at bit centres (offset 542, pitch 1085) decodes 0,1,0,1,0,1,1,0,0 then stop=1. tx_busy lasts exactly 10850 cycles.
- Back-to-back: 3 strobes with bytes 8'h12, 8'h34, 8'h56 on consecutive cycles → three frames with no idle gap, 32550 busy cycles, bytes received in order.
- Overflow: 20 strobes on consecutive cycles with bytes 0..19 → bytes 0..16 transmitted (16 buffered + 1 in flight), fifo_ovf=1 from the cycle the first byte is dropped, and it stays 1.
- Push at full with pop: fill FIFO to 16 while a frame is in STOP, then strobe in the same cycle as the pop → byte accepted, fifo_ovf remains 0.
- Reset mid-frame: assert rst_n low during DATA bit 4 → uart_tx=1 and tx_busy=0 asynchronously. After release, no residual bytes are sent; a new byte 8'hA5 transmits correctly.
